// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - LSB-first serial word transmitter with overlapping pattern match counter
module seq_pattern_tx #(
  parameter int              WIDTH   = 16,
  parameter int              PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b0110,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             clear_cnt,
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HVW = $clog2(PLEN);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             ready_q, ready_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PLEN-2:0]  hist_q, hist_d;
  logic [HVW-1:0]   hv_q, hv_d;

  // Current bit appended to the history, oldest bit in the MSB.
  logic [PLEN-1:0]  window;
  logic             match;

  // Transmit FSM: capture on load, then present one bit per cycle and pulse done on return to idle.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ready_d   = ready_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        dout_d  = 1'b0;
        valid_d = 1'b0;
        if (load) begin
          shreg_d   = data >> 1;
          dout_d    = data[0];
          valid_d   = 1'b1;
          ready_d   = 1'b0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == BCW'(WIDTH - 1)) begin
          state_d = IDLE;
          ready_d = 1'b1;
          valid_d = 1'b0;
          dout_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          dout_d    = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pattern history and saturating match count; clear wins over a same-cycle match.
  always_comb begin
    window = {hist_q, dout_q};
    match  = valid_q && (hv_q == HVW'(PLEN - 1)) && (window == PATTERN);
    hist_d = hist_q;
    hv_d   = hv_q;
    cnt_d  = cnt_q;
    if (clear_cnt) begin
      hist_d = '0;
      hv_d   = '0;
      cnt_d  = '0;
    end else if (valid_q) begin
      hist_d = window[PLEN-2:0];
      if (hv_q != HVW'(PLEN - 1)) begin
        hv_d = hv_q + HVW'(1);
      end
      if (match && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State register with synchronous reset; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      ready_q   <= 1'b1;
      dout_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      hist_q    <= '0;
      hv_q      <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ready_q   <= ready_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      hist_q    <= hist_d;
      hv_q      <= hv_d;
    end
  end

  assign ready      = ready_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign done       = done_q;
  assign match_cnt  = cnt_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;

  localparam int WIDTH = 16;
  localparam int PLEN  = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, load, clear_cnt;
  logic [WIDTH-1:0] data;
  logic             ready, dout, dout_valid, done;
  logic [CNT_W-1:0] match_cnt;

  logic             s_load;
  logic [WIDTH-1:0] s_data;
  logic             s_ready, s_dout, s_valid, s_done;
  logic [1:0]       s_cnt;

  seq_pattern_tx #(.WIDTH(WIDTH), .PLEN(PLEN), .PATTERN(4'b0110), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .load(load), .data(data), .clear_cnt(clear_cnt),
    .ready(ready), .dout(dout), .dout_valid(dout_valid), .done(done), .match_cnt(match_cnt)
  );

  seq_pattern_tx #(.WIDTH(WIDTH), .PLEN(PLEN), .PATTERN(4'b0110), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .load(s_load), .data(s_data), .clear_cnt(1'b0),
    .ready(s_ready), .dout(s_dout), .dout_valid(s_valid), .done(s_done), .match_cnt(s_cnt)
  );

  int cmp_n  = 0;
  int fail_n = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of bits still to send and a sliding window of sent bits.
  logic [3:0] pat_v = 4'b0110;
  bit  m_ready = 1'b1, m_valid = 1'b0, m_dout = 1'b0, m_done = 1'b0;
  int  m_cnt = 0;
  bit  m_tx[$];
  bit  m_win[$];

  task automatic model_step();
    bit was_ready, was_valid, hit;
    if (reset) begin
      m_ready = 1'b1; m_valid = 1'b0; m_dout = 1'b0; m_done = 1'b0; m_cnt = 0;
      m_tx.delete(); m_win.delete();
    end else begin
      was_ready = m_ready;
      was_valid = m_valid;
      if (clear_cnt) begin
        m_cnt = 0;
        m_win.delete();
      end else if (m_valid) begin
        m_win.push_back(m_dout);
        if (m_win.size() > PLEN) void'(m_win.pop_front());
        hit = (m_win.size() == PLEN);
        for (int i = 0; i < PLEN; i++) if (m_win[i] != pat_v[PLEN-1-i]) hit = 1'b0;
        if (hit && m_cnt < 255) m_cnt++;
      end
      if (was_ready && load) for (int i = 0; i < WIDTH; i++) m_tx.push_back(data[i]);
      if (m_tx.size() > 0) begin
        m_dout = m_tx.pop_front(); m_valid = 1'b1; m_ready = 1'b0; m_done = 1'b0;
      end else begin
        m_dout = 1'b0; m_valid = 1'b0; m_ready = 1'b1; m_done = was_valid;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("ready", ready, m_ready);
      chk("dout_valid", dout_valid, m_valid);
      chk("dout", dout, m_dout);
      chk("done", done, m_done);
      chk("match_cnt", match_cnt, m_cnt);
    end
  end

  task automatic send_word(input logic [WIDTH-1:0] d, input int glitch_at, input int clear_at,
                           output int lat, output int first_v, output logic [WIDTH-1:0] got);
    int n;
    int cyc;
    n = 0; cyc = 0; first_v = -1; got = '0; lat = -1;
    load = 1'b1; data = d;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      load = 1'b0; clear_cnt = 1'b0;
      if (cyc == glitch_at) begin load = 1'b1; data = ~d; end
      if (cyc == clear_at) clear_cnt = 1'b1;
      if (dout_valid) begin
        if (first_v < 0) first_v = cyc;
        if (n < WIDTH) got[n] = dout;
        n++;
      end
      if (done) begin lat = cyc; break; end
    end
    load = 1'b0; clear_cnt = 1'b0;
    if (lat < 0) chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  int               lat, fv;
  logic [WIDTH-1:0] got;

  initial begin
    reset = 1'b1; load = 1'b0; clear_cnt = 1'b0; data = '0; s_load = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", match_cnt, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    send_word(16'b0011001101011010, -1, -1, lat, fv, got);
    chk("t1_bits", got, 16'h335A);
    chk("t1_latency", lat, 17);
    chk("t1_cnt", match_cnt, 3);

    send_word(16'h0006, -1, -1, lat, fv, got);
    chk("t2a_cnt", match_cnt, 1 + 3);
    send_word(16'h0003, -1, -1, lat, fv, got);
    chk("t2b_gap", fv, 1);
    chk("t2b_latency", lat, 17);
    chk("t2b_cnt", match_cnt, 2 + 3);

    send_word(16'h1234, 5, -1, lat, fv, got);
    chk("t3_bits", got, 16'h1234);
    chk("t3_latency", lat, 17);
    chk("t3_cnt", match_cnt, 6);

    send_word(16'b0011011011011011, -1, -1, lat, fv, got);
    chk("t4_cnt", match_cnt, 6 + 5);
    send_word(16'h0066, -1, 4, lat, fv, got);
    chk("t4_clear_cnt", match_cnt, 1);

    load = 1'b1; data = 16'h0F0F;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      load = 1'b0;
    end
    chk("t5_mid_valid", dout_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_valid", dout_valid, 0);
    chk("t5_ready", ready, 1);
    chk("t5_cnt", match_cnt, 0);
    send_word(16'h0003, -1, -1, lat, fv, got);
    chk("t5_latency", lat, 17);
    chk("t5_nofalse", match_cnt, 0);

    s_load = 1'b1; s_data = 16'h6666;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      s_load = 1'b0;
      if (c == 9) chk("sat_mid", s_cnt, 2);
    end
    chk("sat_done1", s_done, 1);
    chk("sat_cnt1", s_cnt, 3);
    s_load = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      s_load = 1'b0;
    end
    chk("sat_done2", s_done, 1);
    chk("sat_cnt2", s_cnt, 3);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
